// File: rtl/pacman_score_ctrl.sv
// Game supervisor for the Pac-Man playfield: scoring, candy count, tick timer,
// game-state FSM and a persistent high score.
module pacman_score_ctrl #(
  parameter int WIDTH      = 8,
  parameter int HEIGHT     = 8,
  parameter int SCORE_W    = 16,
  parameter int CANDY_PTS  = 10,
  parameter int TIME_LIMIT = 1024,
  parameter int TIMER_W    = 11,
  parameter int CNT_W      = 7
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [WIDTH-1:0]        pacman_x,
  input  logic [HEIGHT-1:0]       pacman_y,
  input  logic [WIDTH*HEIGHT-1:0] candies,
  input  logic                    catch,
  output logic [2:0]              state,
  output logic [SCORE_W-1:0]      score,
  output logic [SCORE_W-1:0]      high_score,
  output logic [CNT_W-1:0]        candies_left,
  output logic [TIMER_W-1:0]      ticks,
  output logic                    eat_pulse,
  output logic                    frozen,
  output logic                    game_over
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PLAYING = 3'd1,
    WON     = 3'd2,
    LOST    = 3'd3,
    TIMEOUT = 3'd4
  } state_t;

  localparam int AW = $clog2(WIDTH*HEIGHT);

  state_t             cur, nxt;
  logic [AW-1:0]      idx;
  logic               eat;
  logic               terminal;
  logic               restart;
  logic [SCORE_W:0]   sum;
  logic [SCORE_W-1:0] score_nxt;

  assign terminal = (cur == WON) || (cur == LOST) || (cur == TIMEOUT);
  assign restart  = start && ((cur == IDLE) || terminal);

  // Range check gates the index so an off-board position never reads the map.
  assign idx = AW'(pacman_x * HEIGHT + pacman_y);
  assign eat = (cur == PLAYING) && (32'(pacman_x) < WIDTH) &&
               (32'(pacman_y) < HEIGHT) && candies[idx];

  assign sum       = {1'b0, score} + (SCORE_W+1)'(CANDY_PTS);
  assign score_nxt = !eat ? score : (sum[SCORE_W] ? '1 : sum[SCORE_W-1:0]);

  always_comb begin
    nxt = cur;
    case (cur)
      IDLE:    if (start) nxt = PLAYING;
      PLAYING: begin
        if (catch)
          nxt = LOST;
        else if (candies_left == '0 && ticks >= TIMER_W'(2))
          nxt = WON;
        else if (ticks == TIMER_W'(TIME_LIMIT-1))
          nxt = TIMEOUT;
      end
      WON, LOST, TIMEOUT: if (start) nxt = PLAYING;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur          <= IDLE;
      score        <= '0;
      high_score   <= '0;
      candies_left <= '0;
      ticks        <= '0;
      eat_pulse    <= 1'b0;
    end else begin
      cur          <= nxt;
      candies_left <= CNT_W'($countones(candies));
      eat_pulse    <= eat;
      if (restart) begin
        score <= '0;
        ticks <= '0;
      end else begin
        score <= score_nxt;
        // The exit cycle is not counted, so a timeout leaves ticks at TIME_LIMIT-1.
        if (cur == PLAYING && nxt == PLAYING)
          ticks <= ticks + 1'b1;
      end
      if (cur == PLAYING && nxt != PLAYING && score_nxt > high_score)
        high_score <= score_nxt;
    end
  end

  assign state     = cur;
  assign frozen    = (cur != PLAYING);
  assign game_over = terminal;

endmodule

// File: tb/tb_pacman_score_ctrl.sv
// Directed bench for pacman_score_ctrl: eat-vector table plus multi-game sequences.
module tb_pacman_score_ctrl;

  localparam logic [63:0] B63 = 64'h8000_0000_0000_0000;

  logic        clk = 1'b0;
  logic        rst_n, start, catch;
  logic [7:0]  pacman_x, pacman_y;
  logic [63:0] candies;

  logic [2:0]  state, state2;
  logic [15:0] score, high_score;
  logic [4:0]  score2, high_score2;
  logic [6:0]  candies_left, candies_left2;
  logic [10:0] ticks, ticks2;
  logic        eat_pulse, frozen, game_over;
  logic        eat_pulse2, frozen2, game_over2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pacman_score_ctrl #(.TIME_LIMIT(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pacman_x(pacman_x),
    .pacman_y(pacman_y), .candies(candies), .catch(catch), .state(state),
    .score(score), .high_score(high_score), .candies_left(candies_left),
    .ticks(ticks), .eat_pulse(eat_pulse), .frozen(frozen), .game_over(game_over)
  );

  // Narrow score width so saturation is reachable in a few eats.
  pacman_score_ctrl #(.TIME_LIMIT(16), .SCORE_W(5)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .pacman_x(pacman_x),
    .pacman_y(pacman_y), .candies(candies), .catch(catch), .state(state2),
    .score(score2), .high_score(high_score2), .candies_left(candies_left2),
    .ticks(ticks2), .eat_pulse(eat_pulse2), .frozen(frozen2), .game_over(game_over2)
  );

  typedef struct {
    logic [7:0]  x;
    logic [7:0]  y;
    logic [63:0] map;
    logic        pulse;
    logic [15:0] score;
    logic [6:0]  left;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0] = '{8'd1, 8'd1, B63 | 64'h200,        1'b1, 16'd10, 7'd2};
    vecs[1] = '{8'd0, 8'd0, B63,                  1'b0, 16'd10, 7'd1};
    vecs[2] = '{8'd2, 8'd3, B63 | 64'h8_0000,     1'b1, 16'd20, 7'd2};
    vecs[3] = '{8'd8, 8'd0, {64{1'b1}},           1'b0, 16'd20, 7'd64};
    vecs[4] = '{8'd0, 8'd8, {64{1'b1}},           1'b0, 16'd20, 7'd64};
    vecs[5] = '{8'd7, 8'd7, B63,                  1'b1, 16'd30, 7'd1};
    vecs[6] = '{8'd3, 8'd0, B63 | 64'h100_0000,   1'b1, 16'd40, 7'd2};
    vecs[7] = '{8'd0, 8'd0, B63 | 64'h1,          1'b1, 16'd50, 7'd2};

    rst_n = 1'b0; start = 1'b0; catch = 1'b0;
    pacman_x = '0; pacman_y = '0; candies = '0;
    step(); step();
    chk("rst_state", 32'(state), 0);
    chk("rst_score", 32'(score), 0);
    chk("rst_hs", 32'(high_score), 0);
    chk("rst_frozen", 32'(frozen), 1);
    chk("rst_over", 32'(game_over), 0);
    chk("rst_left", 32'(candies_left), 0);
    rst_n = 1'b1;

    // Eat table inside one game
    candies = B63; start = 1'b1;
    step();
    start = 1'b0;
    chk("start_state", 32'(state), 1);
    chk("start_frozen", 32'(frozen), 0);
    for (int i = 0; i < 8; i++) begin
      pacman_x = vecs[i].x; pacman_y = vecs[i].y; candies = vecs[i].map;
      step();
      chk($sformatf("vec%0d_pulse", i), 32'(eat_pulse), 32'(vecs[i].pulse));
      chk($sformatf("vec%0d_score", i), 32'(score), 32'(vecs[i].score));
      chk($sformatf("vec%0d_left", i), 32'(candies_left), 32'(vecs[i].left));
    end
    chk("table_ticks", 32'(ticks), 8);
    chk("table_state", 32'(state), 1);

    // Mid-game reset
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mrst_state", 32'(state), 0);
    chk("mrst_score", 32'(score), 0);
    chk("mrst_hs", 32'(high_score), 0);
    chk("mrst_ticks", 32'(ticks), 0);

    // Catch beats win
    pacman_x = 8'd0; pacman_y = 8'd0; candies = B63; start = 1'b1;
    step();
    start = 1'b0;
    chk("cw_ticks0", 32'(ticks), 0);
    repeat (4) step();
    candies = '0;
    step();
    chk("cw_ticks5", 32'(ticks), 5);
    chk("cw_left0", 32'(candies_left), 0);
    chk("cw_still_play", 32'(state), 1);
    catch = 1'b1;
    step();
    chk("cw_lost", 32'(state), 3);
    chk("cw_over", 32'(game_over), 1);

    // Game 1: 30 points then caught
    catch = 1'b0; candies = B63; start = 1'b1;
    step();
    start = 1'b0;
    chk("g1_score0", 32'(score), 0);
    pacman_x = 8'd7; pacman_y = 8'd7;
    repeat (3) step();
    pacman_x = 8'd0; pacman_y = 8'd0; catch = 1'b1;
    step();
    chk("g1_state", 32'(state), 3);
    chk("g1_score", 32'(score), 30);
    chk("g1_hs", 32'(high_score), 30);

    // Game 2: 20 points then won
    catch = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    pacman_x = 8'd7; pacman_y = 8'd7;
    repeat (2) step();
    pacman_x = 8'd0; pacman_y = 8'd0; candies = '0;
    step();
    chk("g2_guard_play", 32'(state), 1);
    step();
    chk("g2_state", 32'(state), 2);
    chk("g2_score", 32'(score), 20);
    chk("g2_hs", 32'(high_score), 30);
    step();
    chk("g2_hold_state", 32'(state), 2);
    chk("g2_hold_score", 32'(score), 20);

    // Game 3: 40 points, last eat on the losing edge
    candies = B63; start = 1'b1;
    step();
    start = 1'b0;
    pacman_x = 8'd7; pacman_y = 8'd7;
    repeat (3) step();
    catch = 1'b1;
    step();
    chk("g3_state", 32'(state), 3);
    chk("g3_score", 32'(score), 40);
    chk("g3_hs", 32'(high_score), 40);
    chk("g3_pulse", 32'(eat_pulse), 1);
    chk("sat_score", 32'(score2), 31);
    chk("sat_hs", 32'(high_score2), 31);
    chk("sat_state", 32'(state2), 3);
    chk("sat_flags", 32'({frozen2, game_over2, eat_pulse2}), 7);
    chk("sat_ticks", 32'(ticks2), 3);
    chk("sat_left", 32'(candies_left2), 1);

    // Timeout, with start held high early (must be ignored while playing)
    catch = 1'b0; pacman_x = 8'd0; pacman_y = 8'd0; start = 1'b1;
    step();
    begin
      int n = 0;
      while (state != 3'd4 && n < 40) begin
        start = (n < 3);
        step();
        n++;
      end
      start = 1'b0;
      chk("to_cycles", 32'(n), 16);
    end
    chk("to_state", 32'(state), 4);
    chk("to_ticks", 32'(ticks), 15);
    step();
    chk("to_hold_state", 32'(state), 4);
    chk("to_hold_ticks", 32'(ticks), 15);
    chk("to_frozen", 32'(frozen), 1);
    chk("to_score", 32'(score), 0);
    chk("to_hs", 32'(high_score), 40);

    rst_n = 1'b0;
    step();
    chk("frst_hs", 32'(high_score), 0);
    chk("frst_state", 32'(state), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pacman_score_ctrl.md
Name: pacman_score_ctrl

Overview:
- Game-supervision stage directly downstream of the Pac-Man playfield block.
- Consumes Pac-Man position, the candy map and the sticky catch flag.
- Produces score, remaining-candy count, elapsed-tick timer, a game-state FSM (idle/playing/won/lost/timeout) and a persistent high score.
- The `frozen` output gates the playfield's move source at top level.

Parameters:
- WIDTH, 8, playfield columns; must match the playfield block.
- HEIGHT, 8, playfield rows; must match the playfield block.
- SCORE_W, 16, score and high-score width.
- CANDY_PTS, 10, points added per candy eaten.
- TIME_LIMIT, 1024, playing-cycle budget before timeout; must be ≥2.
- TIMER_W, 11, tick counter width; must hold TIME_LIMIT.
- CNT_W, 7, candy counter width; must hold WIDTH*HEIGHT.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  level; begins or restarts a game
- pacman_x  in  WIDTH  Pac-Man column index (binary)
- pacman_y  in  HEIGHT  Pac-Man row index (binary)
- candies  in  WIDTH*HEIGHT  candy map; bit x*HEIGHT+y = cell (x,y)
- catch  in  1  sticky ghost-caught flag from the playfield
- state  out  3  0=IDLE 1=PLAYING 2=WON 3=LOST 4=TIMEOUT
- score  out  SCORE_W  current game score
- high_score  out  SCORE_W  best score since reset
- candies_left  out  CNT_W  registered popcount of candies
- ticks  out  TIMER_W  cycles spent in PLAYING this game
- eat_pulse  out  1  one-cycle strobe per candy eaten
- frozen  out  1  high when state != PLAYING
- game_over  out  1  high in WON, LOST or TIMEOUT

Behaviour:
- Clock and reset: single clock; reset is synchronous and active-low (rst_n sampled on posedge clk).
- Reset values: all outputs 0, except state=IDLE and frozen=1. Reset mid-game aborts it immediately; high_score is cleared only by rst_n.
- candies_left: popcount of candies, registered; 1-cycle latency.
- Eat detect (combinational): eat = (state==PLAYING) && pacman_x<WIDTH && pacman_y<HEIGHT && candies[pacman_x*HEIGHT+pacman_y]. An out-of-range index gives eat=0.
- Eat response: next cycle eat_pulse=1 and score += CANDY_PTS, saturating at 2^SCORE_W-1.
- Ticks: increment each PLAYING cycle; hold in all other states.
- IDLE: on start=1 -> PLAYING; score and ticks cleared.
- PLAYING, transitions evaluated each cycle in this priority order:
  - catch=1 -> LOST (highest priority).
  - else candies_left==0 and ticks≥2 -> WON. The ticks guard masks the stale count right after a restart.
  - else ticks==TIME_LIMIT-1 -> TIMEOUT.
- Same-cycle eat and terminal event: the eat is still scored; the state change takes effect on the same edge.
- Terminal states (WON/LOST/TIMEOUT):
  - On entry (same edge), high_score <= max(high_score, final score). The final score includes any eat on the transition cycle.
  - start=1 -> PLAYING with score and ticks cleared.
  - start=0 -> hold; score and ticks frozen.
- start while PLAYING is ignored.
- frozen and game_over are combinational decodes of the registered state.
- Unused state encodings 5–7 recover to IDLE on the next edge.

Test Plan:
- Reset: rst_n=0 for 2 cycles, then 1 -> state=0, score=0, high_score=0, frozen=1.
- Single eat: start; next cycle candy bit at (1,1) set with pacman at (1,1) -> eat_pulse high for exactly 1 cycle, score=10.
- Catch beats win: catch=1 in the same cycle candies_left==0 and ticks=5 -> state=3 (LOST).
- Timeout: TIME_LIMIT=16, no candies eaten, catch=0 -> state=4 after exactly 16 PLAYING cycles; ticks holds at 15.
- High score: game 1 scores 30 then LOST; game 2 scores 20 then WON -> high_score stays 30. A third game scoring 40 -> high_score=40.
- Mid-game reset: rst_n=0 while PLAYING with score=50 -> next cycle state=IDLE, score=0, high_score=0.
